// File: rtl/seg7_pkg.sv
// seg7_pkg: segment pattern constants shared by the seven-segment display driver and the scan reader.
// Patterns are active-low over {a,b,c,d,e,f,g}: bit 6 = a ... bit 0 = g.
package seg7_pkg;
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001101;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0001100;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [3:0] DIG_BLANK = 4'hF;
  localparam logic [3:0] DIG_ERR = 4'hE;
endpackage

// File: rtl/seg7_pattern_decode.sv
// seg7_pattern_decode: active-low 7-segment pattern back to a digit code.
// Ports: pat (segments a..g, active-low) in; code (0-9, F blank, E error) and err out.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] code,
  output logic       err
);
  always_comb begin
    err = 1'b0;
    case (pat)
      SEG_0: code = 4'd0;
      SEG_1: code = 4'd1;
      SEG_2: code = 4'd2;
      SEG_3: code = 4'd3;
      SEG_4: code = 4'd4;
      SEG_5: code = 4'd5;
      SEG_6: code = 4'd6;
      SEG_7: code = 4'd7;
      SEG_8: code = 4'd8;
      SEG_9: code = 4'd9;
      SEG_BLANK: code = DIG_BLANK;
      default: begin
        code = DIG_ERR;
        err = 1'b1;
      end
    endcase
  end
endmodule

// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader: samples a multiplexed active-low segment bus, decodes stable digits and publishes whole frames.
// Ports: clk, rst (async active-low), seg_in (a..g,dp active-low), dig_in_n (active-low selects), clr (sync
// partial-frame clear); bcd_out/err_out/dp_out hold the last frame, frame_valid pulses once per publish.
module seg7_scan_reader
  import seg7_pkg::*;
#(
  parameter int NDIG = 4,
  parameter int STABLE = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        seg_in,
  input  logic [NDIG-1:0]   dig_in_n,
  input  logic              clr,
  output logic [4*NDIG-1:0] bcd_out,
  output logic [NDIG-1:0]   err_out,
  output logic [NDIG-1:0]   dp_out,
  output logic              frame_valid
);
  localparam logic [3:0] STB = 4'(STABLE);
  logic [NDIG+7:0] s_q;
  logic [3:0] cnt, cnt_nx, code;
  logic [NDIG-1:0] mask, mask_nx, sh_err, sh_dp, err_nx, dp_nx, sel;
  logic [4*NDIG-1:0] sh_bcd, bcd_nx;
  logic same, one_low, capture, err;
  assign sel = ~dig_in_n;
  assign one_low = (sel != '0) && ((sel & (sel - NDIG'(1))) == '0);
  assign same = {dig_in_n, seg_in} == s_q;
  assign cnt_nx = !(same && one_low) ? 4'd0 : (cnt == STB) ? cnt : cnt + 4'd1;
  // Fires only on the STABLE-1 -> STABLE step, so a held input captures once.
  assign capture = same && one_low && cnt == STB - 4'd1;
  seg7_pattern_decode u_dec (
    .pat(s_q[7:1]),
    .code(code),
    .err(err)
  );
  always_comb begin
    bcd_nx = sh_bcd;
    err_nx = sh_err;
    dp_nx = sh_dp;
    mask_nx = mask | sel;
    for (int i = 0; i < NDIG; i++) begin
      bcd_nx[4*i+:4] = sel[i] ? code : sh_bcd[4*i+:4];
      err_nx[i] = sel[i] ? err : sh_err[i];
      dp_nx[i] = sel[i] ? ~s_q[0] : sh_dp[i];
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s_q <= '1;
      cnt <= '0;
      mask <= '0;
      sh_bcd <= {NDIG{DIG_BLANK}};
      sh_err <= '0;
      sh_dp <= '0;
      bcd_out <= {NDIG{DIG_BLANK}};
      err_out <= '0;
      dp_out <= '0;
      frame_valid <= 1'b0;
    end else begin
      s_q <= {dig_in_n, seg_in};
      frame_valid <= 1'b0;
      if (clr) begin
        cnt <= '0;
        mask <= '0;
        sh_bcd <= {NDIG{DIG_BLANK}};
        sh_err <= '0;
        sh_dp <= '0;
      end else begin
        cnt <= cnt_nx;
        if (capture) begin
          sh_bcd <= bcd_nx;
          sh_err <= err_nx;
          sh_dp <= dp_nx;
          mask <= &mask_nx ? '0 : mask_nx;
          if (&mask_nx) begin
            bcd_out <= bcd_nx;
            err_out <= err_nx;
            dp_out <= dp_nx;
            frame_valid <= 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_reader.sv
// tb_seg7_scan_reader: directed scoreboard bench for seg7_scan_reader (NDIG=4, STABLE=4).
module tb_seg7_scan_reader;
  logic clk = 1'b0, rst = 1'b0, clr = 1'b0;
  logic [7:0] seg_in = 8'hFF;
  logic [3:0] dig_in_n = 4'hF;
  logic [15:0] bcd_out;
  logic [3:0] err_out, dp_out;
  logic frame_valid;
  int checks = 0, errors = 0;
  logic [23:0] exp_q[$];
  seg7_scan_reader #(.NDIG(4), .STABLE(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .dig_in_n(dig_in_n), .clr(clr),
    .bcd_out(bcd_out), .err_out(err_out), .dp_out(dp_out), .frame_valid(frame_valid)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask
  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_frame", 32'(frame_valid), 32'd0);
      else begin
        logic [23:0] e;
        e = exp_q.pop_front();
        chk("frame_bcd", 32'(bcd_out), 32'(e[23:8]));
        chk("frame_err", 32'(err_out), 32'(e[7:4]));
        chk("frame_dp", 32'(dp_out), 32'(e[3:0]));
      end
    end
  end
  task automatic hold(input logic [3:0] d, input logic [7:0] s, input int n);
    dig_in_n = d;
    seg_in = s;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic frame(input logic [7:0] s0, s1, s2, s3, input int n);
    hold(4'b1110, s0, n);
    hold(4'b1101, s1, n);
    hold(4'b1011, s2, n);
    hold(4'b0111, s3, n);
    hold(4'hF, 8'hFF, 2);
  endtask
  task automatic outs(input string tag, input logic [15:0] b, input logic [3:0] e, input logic [3:0] p);
    chk({tag, "_bcd"}, 32'(bcd_out), 32'(b));
    chk({tag, "_err"}, 32'(err_out), 32'(e));
    chk({tag, "_dp"}, 32'(dp_out), 32'(p));
  endtask
  initial begin
    repeat (3) begin
      seg_in = 8'($urandom);
      dig_in_n = 4'($urandom);
      @(posedge clk);
      #1;
      outs("reset", 16'hFFFF, 4'h0, 4'h0);
      chk("reset_fv", 32'(frame_valid), 32'd0);
    end
    rst = 1'b1;
    hold(4'hF, 8'hFF, 2);
    exp_q.push_back({16'h4321, 4'h0, 4'h0});
    frame(8'h9F, 8'h25, 8'h0D, 8'h99, 6);
    outs("full", 16'h4321, 4'h0, 4'h0);
    frame(8'h49, 8'h41, 8'h1B, 8'h01, 4);
    outs("short", 16'h4321, 4'h0, 4'h0);
    exp_q.push_back({16'h4E21, 4'b0100, 4'b1111});
    frame(8'h9E, 8'h24, 8'h6E, 8'h98, 6);
    outs("badpat", 16'h4E21, 4'b0100, 4'b1111);
    hold(4'b1100, 8'h9F, 10);
    hold(4'hF, 8'hFF, 2);
    outs("glitch", 16'h4E21, 4'b0100, 4'b1111);
    hold(4'b1110, 8'h03, 6);
    hold(4'b1101, 8'h49, 6);
    hold(4'b1100, 8'h41, 10);
    exp_q.push_back({16'h7650, 4'h0, 4'h0});
    hold(4'b1011, 8'h41, 6);
    hold(4'b0111, 8'h1B, 6);
    hold(4'hF, 8'hFF, 2);
    outs("glitch_mask", 16'h7650, 4'h0, 4'h0);
    hold(4'b1110, 8'h01, 6);
    hold(4'b1101, 8'h19, 6);
    hold(4'b1011, 8'h9F, 6);
    clr = 1'b1;
    hold(4'hF, 8'hFF, 1);
    clr = 1'b0;
    hold(4'b0111, 8'h25, 6);
    hold(4'hF, 8'hFF, 2);
    outs("clr_hold", 16'h7650, 4'h0, 4'h0);
    exp_q.push_back({16'h2198, 4'h0, 4'h0});
    hold(4'b1110, 8'h01, 6);
    hold(4'b1101, 8'h19, 6);
    hold(4'b1011, 8'h9F, 6);
    hold(4'hF, 8'hFF, 2);
    outs("clr_recap", 16'h2198, 4'h0, 4'h0);
    exp_q.push_back({16'hF333, 4'h0, 4'h0});
    frame(8'h0D, 8'h0D, 8'h0D, 8'hFF, 6);
    outs("blank", 16'hF333, 4'h0, 4'h0);
    hold(4'b1110, 8'h9F, 6);
    hold(4'b1101, 8'h25, 6);
    rst = 1'b0;
    #1;
    outs("midreset", 16'hFFFF, 4'h0, 4'h0);
    hold(4'hF, 8'hFF, 1);
    rst = 1'b1;
    hold(4'b1011, 8'h0D, 6);
    hold(4'b0111, 8'h99, 6);
    hold(4'hF, 8'hFF, 3);
    outs("after_reset", 16'hFFFF, 4'h0, 4'h0);
    chk("pending_frames", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
